// File: rtl/scm_rr_port_ctrl.sv
// Purpose : shares one latch-based 1R/1W SCM between NUM_PORTS requesters with
//           independent round-robin read and write arbiters, plus a post-reset init sweep.
// Latency : grants are combinational (0 cycles); read data returns 1 cycle after grant.
// Backpressure: a requester holds req/addr/data until granted; no grants during init sweep.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   rd_req_i/rd_addr_i/rd_gnt_o     read request, packed per-port address, one-hot grant
//   rd_valid_o/rd_data_o            one-hot response valid and shared response data
//   wr_req_i/wr_addr_i/wr_data_i    write request, packed per-port address and data
//   wr_gnt_o                        one-hot write grant
//   init_done_o                     high once every word holds INIT_VALUE
//   scm_*                           SCM read/write port (read data valid cycle after re)
module scm_rr_port_ctrl #(
  parameter int                     NUM_PORTS  = 4,
  parameter int                     ADDR_WIDTH = 5,
  parameter int                     DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            rd_req_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_PORTS-1:0]            rd_gnt_o,
  output logic [NUM_PORTS-1:0]            rd_valid_o,
  output logic [DATA_WIDTH-1:0]           rd_data_o,
  input  logic [NUM_PORTS-1:0]            wr_req_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data_i,
  output logic [NUM_PORTS-1:0]            wr_gnt_o,
  output logic                            init_done_o,
  output logic                            scm_re_o,
  output logic [ADDR_WIDTH-1:0]           scm_raddr_o,
  input  logic [DATA_WIDTH-1:0]           scm_rdata_i,
  output logic                            scm_we_o,
  output logic [ADDR_WIDTH-1:0]           scm_waddr_o,
  output logic [DATA_WIDTH-1:0]           scm_wdata_o
);

  localparam int             PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W:0] NP    = (PTR_W+1)'(NUM_PORTS);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Returns {found, index}: first requesting port at or after ptr, wrapping.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                             input logic [PTR_W-1:0]     ptr);
    logic [PTR_W:0] res;
    logic [PTR_W:0] pos;
    res = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(i);
      if (pos >= NP) pos = pos - NP;
      if (!res[PTR_W] && req[pos[PTR_W-1:0]]) res = {1'b1, pos[PTR_W-1:0]};
    end
    return res;
  endfunction

  // (idx + 1) mod NUM_PORTS, correct for non-power-of-two port counts.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
    logic [PTR_W:0] nxt;
    nxt = {1'b0, idx} + (PTR_W+1)'(1);
    if (nxt == NP) nxt = '0;
    return nxt[PTR_W-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [NUM_PORTS-1:0]    rd_valid_q, rd_valid_d;
  logic                    byp_vld_q, byp_vld_d;
  logic [DATA_WIDTH-1:0]   byp_dat_q, byp_dat_d;

  logic                    arb_en;
  logic [PTR_W:0]          rd_pick, wr_pick;
  logic                    rd_hit, wr_hit;
  logic [PTR_W-1:0]        rd_idx, wr_idx;
  logic [ADDR_WIDTH-1:0]   rd_addr_sel, wr_addr_sel;
  logic [DATA_WIDTH-1:0]   wr_data_sel;
  logic [NUM_PORTS-1:0]    rd_gnt, wr_gnt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_valid_d  = '0;
    byp_vld_d   = 1'b0;
    byp_dat_d   = byp_dat_q;
    rd_gnt      = '0;
    wr_gnt      = '0;
    scm_re_o    = 1'b0;
    scm_raddr_o = '0;
    scm_we_o    = 1'b0;
    scm_waddr_o = '0;
    scm_wdata_o = '0;

    // Arbitration only runs once storage holds defined values.
    arb_en      = rst_n && (state_q == ST_RUN);
    rd_pick     = rr_pick(rd_req_i, rd_ptr_q);
    wr_pick     = rr_pick(wr_req_i, wr_ptr_q);
    rd_hit      = arb_en && rd_pick[PTR_W];
    wr_hit      = arb_en && wr_pick[PTR_W];
    rd_idx      = rd_pick[PTR_W-1:0];
    wr_idx      = wr_pick[PTR_W-1:0];
    rd_addr_sel = rd_addr_i[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
    wr_addr_sel = wr_addr_i[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
    wr_data_sel = wr_data_i[wr_idx*DATA_WIDTH +: DATA_WIDTH];

    case (state_q)
      ST_INIT: begin
        scm_we_o    = rst_n;
        scm_waddr_o = cnt_q;
        scm_wdata_o = INIT_VALUE;
        cnt_d       = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_RUN;
      end
      default: begin
        if (rd_hit) begin
          rd_gnt[rd_idx]     = 1'b1;
          rd_valid_d[rd_idx] = 1'b1;
          rd_ptr_d           = rr_next(rd_idx);
          scm_re_o           = 1'b1;
          scm_raddr_o        = rd_addr_sel;
        end
        if (wr_hit) begin
          wr_gnt[wr_idx] = 1'b1;
          wr_ptr_d       = rr_next(wr_idx);
          scm_we_o       = 1'b1;
          scm_waddr_o    = wr_addr_sel;
          scm_wdata_o    = wr_data_sel;
        end
        // The SCM returns the old word when read and written together, so the
        // new data is captured here and substituted on the response.
        if (rd_hit && wr_hit && (rd_addr_sel == wr_addr_sel)) begin
          byp_vld_d = 1'b1;
          byp_dat_d = wr_data_sel;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_valid_q <= '0;
      byp_vld_q  <= 1'b0;
      byp_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_valid_q <= rd_valid_d;
      byp_vld_q  <= byp_vld_d;
      byp_dat_q  <= byp_dat_d;
    end
  end

  // Outputs are forced quiet combinationally while reset is held, so a
  // response registered just before reset is never presented.
  assign rd_gnt_o    = rd_gnt;
  assign wr_gnt_o    = wr_gnt;
  assign init_done_o = rst_n && (state_q == ST_RUN);
  assign rd_valid_o  = rst_n ? rd_valid_q : '0;
  assign rd_data_o   = (rst_n && (|rd_valid_q)) ? (byp_vld_q ? byp_dat_q : scm_rdata_i)
                                                : '0;

endmodule

// File: tb/tb_scm_rr_port_ctrl.sv
// Directed bench for scm_rr_port_ctrl with a behavioural 1R/1W SCM attached.
module tb_scm_rr_port_ctrl;
  localparam int NP = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     rd_req, rd_gnt, rd_valid, wr_req, wr_gnt;
  logic [NP*AW-1:0]  rd_addr, wr_addr;
  logic [NP*DW-1:0]  wr_data;
  logic [DW-1:0]     rd_data;
  logic              init_done;
  logic              scm_re, scm_we;
  logic [AW-1:0]     scm_raddr, scm_waddr;
  logic [DW-1:0]     scm_rdata, scm_wdata;

  int total = 0;
  int bad   = 0;

  scm_rr_port_ctrl #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE('0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
    .init_done_o(init_done),
    .scm_re_o(scm_re), .scm_raddr_o(scm_raddr), .scm_rdata_i(scm_rdata),
    .scm_we_o(scm_we), .scm_waddr_o(scm_waddr), .scm_wdata_o(scm_wdata)
  );

  // SCM model: read returns the pre-write contents one cycle after re.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (scm_re) scm_rdata <= mem[scm_raddr];
    if (scm_we) mem[scm_waddr] <= scm_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_req = '0; wr_req = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'hFFFF_FFFF;
    scm_rdata = '0;

    // Reset with all ports requesting; outputs must stay quiet.
    rd_req = 4'b1111; wr_req = 4'b1111;
    for (int p = 0; p < NP; p++) begin
      rd_addr[p*AW +: AW] = AW'(20 + p);
      wr_addr[p*AW +: AW] = AW'(20 + p);
      wr_data[p*DW +: DW] = 32'hA0 + p;
    end
    step(); step();
    check("rst_we", scm_we, 0);
    check("rst_re", scm_re, 0);
    check("rst_rgnt", rd_gnt, 0);
    check("rst_wgnt", wr_gnt, 0);
    check("rst_done", init_done, 0);
    check("rst_rvld", rd_valid, 0);

    // Init sweep: 32 cycles of writes 0..31 of value 0, no grants.
    rst_n = 1'b1;
    for (int c = 0; c < 2**AW; c++) begin
      #1;
      check("init_we", scm_we, 1);
      check("init_waddr", scm_waddr, c);
      check("init_wdata", scm_wdata, 0);
      check("init_rgnt", rd_gnt, 0);
      check("init_wgnt", wr_gnt, 0);
      check("init_done_lo", init_done, 0);
      step();
    end

    // Round-robin reads from pointer 0; the first four coincide with writes to
    // the same address, so they exercise the write-first bypass.
    for (int k = 0; k < 5; k++) begin
      if (k == 4) wr_req = '0;
      #1;
      if (k == 0) check("done_hi", init_done, 1);
      check("rr_rgnt", rd_gnt, 4'b0001 << (k % 4));
      if (k < 4) check("rr_wgnt", wr_gnt, 4'b0001 << k);
      step();
      check("rr_rvld", rd_valid, 4'b0001 << (k % 4));
      check("rr_rdata", rd_data, 32'hA0 + (k % 4));
      if (k < 4) wr_req[k] = 1'b0;
    end
    rd_req = '0;

    // Same-cycle write port1 / read port2 at addr 5.
    rd_req = 4'b0100; rd_addr[2*AW +: AW] = 5;
    wr_req = 4'b0010; wr_addr[1*AW +: AW] = 5; wr_data[1*DW +: DW] = 32'hDEADBEEF;
    #1;
    check("byp_rgnt", rd_gnt, 4'b0100);
    check("byp_wgnt", wr_gnt, 4'b0010);
    check("byp_raddr", scm_raddr, 5);
    check("byp_wdata", scm_wdata, 32'hDEADBEEF);
    step();
    rd_req = '0; wr_req = '0;
    check("byp_rvld", rd_valid, 4'b0100);
    check("byp_rdata", rd_data, 32'hDEADBEEF);
    step();
    check("idle_rvld", rd_valid, 0);
    check("idle_rdata", rd_data, 0);

    // Write addr 7, read it next cycle from the SCM, then read untouched addr 8.
    wr_req = 4'b0001; wr_addr[0 +: AW] = 7; wr_data[0 +: DW] = 32'h0000_1234;
    #1;
    check("w7_wgnt", wr_gnt, 4'b0001);
    step();
    wr_req = '0;
    rd_req = 4'b0001; rd_addr[0 +: AW] = 7;
    #1;
    check("r7_rgnt", rd_gnt, 4'b0001);
    step();
    check("r7_rvld", rd_valid, 4'b0001);
    check("r7_rdata", rd_data, 32'h0000_1234);
    rd_addr[0 +: AW] = 8;
    step();
    rd_req = '0;
    check("r8_rvld", rd_valid, 4'b0001);
    check("r8_rdata", rd_data, 0);

    // Write arbitration: port3 alone, then ports 0/2/3 compete.
    for (int p = 0; p < NP; p++) wr_addr[p*AW +: AW] = 30;
    wr_req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("w3_only", wr_gnt, 4'b1000);
      step();
    end
    wr_req = 4'b1101;
    #1; check("wrr_p0", wr_gnt, 4'b0001); step();
    wr_req = 4'b1100;
    #1; check("wrr_p2", wr_gnt, 4'b0100); step();
    wr_req = 4'b1000;
    #1; check("wrr_p3", wr_gnt, 4'b1000); step();
    wr_req = '0;

    // Reset right after a read grant: response dropped, sweep restarts.
    rd_req = 4'b0010; rd_addr[1*AW +: AW] = 20;
    #1;
    check("pre_rst_rgnt", rd_gnt, 4'b0010);
    step();
    rd_req = '0; rst_n = 1'b0;
    #1;
    check("mid_rst_rvld", rd_valid, 0);
    check("mid_rst_rdata", rd_data, 0);
    check("mid_rst_we", scm_we, 0);
    check("mid_rst_done", init_done, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2**AW; c++) begin
      #1;
      check("reinit_waddr", scm_waddr, c);
      check("reinit_we", scm_we, 1);
      check("reinit_rvld", rd_valid, 0);
      check("reinit_done", init_done, 0);
      step();
    end
    rd_req = 4'b0110;
    #1;
    check("reinit_done_hi", init_done, 1);
    check("reinit_rptr", rd_gnt, 4'b0010);
    step();
    rd_req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
